// File: rtl/alu_ctrl_pkg.sv
// rtl/alu_ctrl_pkg.sv - opcode constants, FSM state type and opcode-legal check for the ALU arbiter
package alu_ctrl_pkg;

    localparam logic [4:0] OP_AND  = 5'b00000;
    localparam logic [4:0] OP_OR   = 5'b00001;
    localparam logic [4:0] OP_ADD  = 5'b00010;
    localparam logic [4:0] OP_SUB  = 5'b01110;
    localparam logic [4:0] OP_SLT  = 5'b01111;
    localparam logic [4:0] OP_NOR  = 5'b11000;
    localparam logic [4:0] OP_NAND = 5'b11001;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    function automatic logic op_legal(input logic [4:0] op);
        case (op)
            OP_AND, OP_OR, OP_ADD, OP_SUB, OP_SLT, OP_NOR, OP_NAND: op_legal = 1'b1;
            default:                                                op_legal = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/ALU32.sv
// rtl/ALU32.sv - 32-bit combinational ALU
module ALU32
    import alu_ctrl_pkg::*;
(
    input  logic [31:0] A,
    input  logic [4:0]  alu_op,
    input  logic [31:0] B,
    output logic [31:0] S
);

    always_comb begin
        S = 32'h0000_0000;
        case (alu_op)
            OP_AND:  S = A & B;
            OP_OR:   S = A | B;
            OP_ADD:  S = A + B;
            OP_SUB:  S = A - B;
            OP_SLT:  S = {31'd0, $signed(A) < $signed(B)};
            OP_NOR:  S = ~(A | B);
            OP_NAND: S = ~(A & B);
            default: S = 32'h0000_0000;
        endcase
    end

endmodule

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-way round-robin grant, pointer decides only when both request
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       ptr,
    output logic [1:0] gnt
);

    always_comb begin
        gnt = req;
        if (req == 2'b11) begin
            gnt = ptr ? 2'b10 : 2'b01;
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - shares one ALU32 between two requesters with round-robin arbitration
module alu_arbiter
    import alu_ctrl_pkg::*;
#(
    parameter logic [31:0] ILLEGAL_RESULT = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  req_valid,
    output logic [1:0]  req_ready,
    input  logic [31:0] req_a0,
    input  logic [31:0] req_b0,
    input  logic [31:0] req_a1,
    input  logic [31:0] req_b1,
    input  logic [4:0]  req_op0,
    input  logic [4:0]  req_op1,
    output logic [1:0]  rsp_valid,
    input  logic [1:0]  rsp_ready,
    output logic [31:0] rsp_data,
    output logic        rsp_err
);

    state_t      state;
    logic        ptr;
    logic        id_q;
    logic [31:0] a_q;
    logic [31:0] b_q;
    logic [4:0]  op_q;
    logic [1:0]  gnt;
    logic [31:0] alu_s;

    rr_arb2 u_arb (
        .req (req_valid),
        .ptr (ptr),
        .gnt (gnt)
    );

    ALU32 u_alu (
        .A      (a_q),
        .alu_op (op_q),
        .B      (b_q),
        .S      (alu_s)
    );

    assign req_ready = (state == IDLE && !rst) ? gnt : 2'b00;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            ptr       <= 1'b0;
            id_q      <= 1'b0;
            a_q       <= 32'h0000_0000;
            b_q       <= 32'h0000_0000;
            op_q      <= 5'b00000;
            rsp_valid <= 2'b00;
            rsp_data  <= 32'h0000_0000;
            rsp_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (gnt != 2'b00) begin
                        a_q   <= gnt[1] ? req_a1  : req_a0;
                        b_q   <= gnt[1] ? req_b1  : req_b0;
                        op_q  <= gnt[1] ? req_op1 : req_op0;
                        id_q  <= gnt[1];
                        // Pointer advances only on a contested grant; a lone requester leaves it alone
                        if (req_valid == 2'b11) begin
                            ptr <= gnt[0];
                        end
                        state <= EXEC;
                    end
                end
                EXEC: begin
                    rsp_data  <= op_legal(op_q) ? alu_s : ILLEGAL_RESULT;
                    rsp_err   <= !op_legal(op_q);
                    rsp_valid <= id_q ? 2'b10 : 2'b01;
                    state     <= RESP;
                end
                RESP: begin
                    if (rsp_ready[id_q]) begin
                        rsp_valid <= 2'b00;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - directed self-checking bench for alu_arbiter
module tb_alu_arbiter;

    logic        clk;
    logic        rst;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [31:0] req_a0, req_b0, req_a1, req_b1;
    logic [4:0]  req_op0, req_op1;
    logic [1:0]  rsp_valid;
    logic [1:0]  rsp_ready;
    logic [31:0] rsp_data;
    logic        rsp_err;

    int n_cmp = 0;
    int n_err = 0;

    alu_arbiter dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a0    (req_a0),
        .req_b0    (req_b0),
        .req_a1    (req_a1),
        .req_b1    (req_b1),
        .req_op0   (req_op0),
        .req_op1   (req_op1),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_err   (rsp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_rsp(input string tag, input logic [1:0] v, input logic [31:0] d, input logic e);
        chk({tag, ".rsp_valid"}, {30'd0, rsp_valid}, {30'd0, v});
        chk({tag, ".rsp_data"},  rsp_data, d);
        chk({tag, ".rsp_err"},   {31'd0, rsp_err}, {31'd0, e});
    endtask

    initial begin
        rst = 1'b1;
        req_valid = 2'b00;
        rsp_ready = 2'b00;
        req_a0 = 0; req_b0 = 0; req_a1 = 0; req_b1 = 0;
        req_op0 = 5'b00000; req_op1 = 5'b00000;
        tick();
        tick();
        req_valid = 2'b01;
        #1;
        chk("reset.req_ready", {30'd0, req_ready}, 32'd0);
        chk_rsp("reset", 2'b00, 32'd0, 1'b0);
        req_valid = 2'b00;
        rst = 1'b0;
        tick();

        // single AND
        req_valid = 2'b01; req_a0 = 45; req_b0 = 21; req_op0 = 5'b00000; rsp_ready = 2'b11;
        #1;
        chk("and.req_ready", {30'd0, req_ready}, 32'd1);
        tick();
        req_valid = 2'b00;
        #1;
        chk("and.exec_ready", {30'd0, req_ready}, 32'd0);
        chk("and.exec_valid", {30'd0, rsp_valid}, 32'd0);
        tick();
        chk_rsp("and", 2'b01, 32'd5, 1'b0);
        tick();
        chk("and.done_valid", {30'd0, rsp_valid}, 32'd0);

        // contested pair after reset: req0 first
        req_valid = 2'b11;
        req_a0 = 45; req_b0 = 21; req_op0 = 5'b00010;
        req_a1 = 45; req_b1 = 21; req_op1 = 5'b01110;
        #1;
        chk("pair1.gnt0", {30'd0, req_ready}, 32'd1);
        tick();
        req_valid = 2'b10;
        tick();
        chk_rsp("pair1.add", 2'b01, 32'd66, 1'b0);
        tick();
        chk("pair1.gnt1", {30'd0, req_ready}, 32'd2);
        tick();
        req_valid = 2'b00;
        tick();
        chk_rsp("pair1.sub", 2'b10, 32'd24, 1'b0);
        tick();

        // second contested pair: req1 first
        req_valid = 2'b11;
        req_a0 = 45; req_b0 = 21; req_op0 = 5'b00001;
        req_a1 = 21; req_b1 = 45; req_op1 = 5'b01111;
        #1;
        chk("pair2.gnt1", {30'd0, req_ready}, 32'd2);
        tick();
        req_valid = 2'b01;
        tick();
        chk_rsp("pair2.slt", 2'b10, 32'd1, 1'b0);
        tick();
        chk("pair2.gnt0", {30'd0, req_ready}, 32'd1);
        tick();
        req_valid = 2'b00;
        tick();
        chk_rsp("pair2.or", 2'b01, 32'd61, 1'b0);
        tick();

        // NOR with back-pressure, req0 waiting
        rsp_ready = 2'b00;
        req_valid = 2'b10; req_a1 = 21; req_b1 = 45; req_op1 = 5'b11000;
        tick();
        req_valid = 2'b11; req_a0 = 1; req_b0 = 2; req_op0 = 5'b00010;
        tick();
        for (int i = 0; i < 5; i++) begin
            chk_rsp("nor.hold", 2'b10, 32'hFFFF_FFC2, 1'b0);
            chk("nor.req_ready", {30'd0, req_ready}, 32'd0);
            tick();
        end
        rsp_ready = 2'b01;
        tick();
        chk("nor.wrong_ready", {30'd0, rsp_valid}, 32'd2);
        rsp_ready = 2'b10;
        tick();
        req_valid = 2'b01;
        #1;
        chk("nor.done_valid", {30'd0, rsp_valid}, 32'd0);
        chk("nor.gnt0", {30'd0, req_ready}, 32'd1);
        tick();
        req_valid = 2'b00;
        rsp_ready = 2'b11;
        tick();
        chk_rsp("waiter.add", 2'b01, 32'd3, 1'b0);
        tick();

        // illegal opcode, then NAND
        req_valid = 2'b01; req_a0 = 45; req_b0 = 21; req_op0 = 5'b00111;
        tick();
        req_valid = 2'b00;
        tick();
        chk_rsp("illegal", 2'b01, 32'h0000_0000, 1'b1);
        tick();
        req_valid = 2'b01; req_a0 = 21; req_b0 = 45; req_op0 = 5'b11001;
        tick();
        req_valid = 2'b00;
        tick();
        chk_rsp("nand", 2'b01, 32'hFFFF_FFFA, 1'b0);
        tick();

        // contested grant to req0 moves pointer to req1
        req_valid = 2'b11;
        req_a0 = 45; req_b0 = 21; req_op0 = 5'b00000;
        req_a1 = 1;  req_b1 = 2;  req_op1 = 5'b00010;
        #1;
        chk("pre_rst.gnt0", {30'd0, req_ready}, 32'd1);
        tick();
        req_valid = 2'b10;
        tick();
        chk_rsp("pre_rst.and", 2'b01, 32'd5, 1'b0);
        tick();
        tick();
        req_valid = 2'b00;
        #1;
        chk("rst.in_exec", {30'd0, req_ready}, 32'd0);
        rst = 1'b1;
        #1;
        chk_rsp("rst.async", 2'b00, 32'd0, 1'b0);
        tick();
        rst = 1'b0;
        tick();
        tick();
        chk("rst.no_rsp_a", {30'd0, rsp_valid}, 32'd0);
        tick();
        chk("rst.no_rsp_b", {30'd0, rsp_valid}, 32'd0);

        req_valid = 2'b11;
        req_a0 = 7; req_b0 = 3; req_op0 = 5'b01110;
        req_a1 = 5; req_b1 = 9; req_op1 = 5'b00010;
        #1;
        chk("post_rst.gnt0", {30'd0, req_ready}, 32'd1);
        tick();
        req_valid = 2'b10;
        tick();
        chk_rsp("post_rst.sub", 2'b01, 32'd4, 1'b0);
        tick();
        tick();
        req_valid = 2'b00;
        tick();
        chk_rsp("post_rst.add", 2'b10, 32'd14, 1'b0);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
